// File: rtl/mor1kx_sb_drain_pkg.sv
// rtl/mor1kx_sb_drain_pkg.sv - shared LSU constants for the store-buffer drain stage
// State encodings, store-buffer entry widths and the watchdog default.
package mor1kx_sb_drain_pkg;

   localparam int SB_OPERAND_WIDTH  = 32;
   localparam int SB_TIMEOUT_CYCLES = 255;

   localparam logic [1:0] SB_ST_IDLE  = 2'd0;
   localparam logic [1:0] SB_ST_FETCH = 2'd1;
   localparam logic [1:0] SB_ST_WRITE = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = SB_ST_IDLE,
      FETCH = SB_ST_FETCH,
      WRITE = SB_ST_WRITE
   } drain_state_t;

   function automatic int bsel_width(input int operand_width);
      return operand_width / 8;
   endfunction

endpackage

// File: rtl/mor1kx_sb_drain_timer.sv
// rtl/mor1kx_sb_drain_timer.sv - ack watchdog for the store-buffer drain stage
// expired is high in the LIMIT-th consecutive enabled cycle after a clear.
module mor1kx_sb_drain_timer
   import mor1kx_sb_drain_pkg::*;
#(
   parameter int LIMIT = SB_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear)
         count <= '0;
      else if (en)
         count <= count + CW'(1);
   end

   assign expired = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mor1kx_sb_drain.sv
// rtl/mor1kx_sb_drain.sv - pops store-buffer entries and issues them as single bus writes
// Optional ack watchdog enabled by defining MOR1KX_SB_DRAIN_TIMEOUT_EN.
module mor1kx_sb_drain
   import mor1kx_sb_drain_pkg::*;
#(
   parameter int  OPTION_OPERAND_WIDTH = SB_OPERAND_WIDTH,
   parameter int  TIMEOUT_CYCLES       = SB_TIMEOUT_CYCLES,
   localparam int BW                   = bsel_width(OPTION_OPERAND_WIDTH)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            sb_empty_i,
   output logic                            sb_read_o,
   input  logic [OPTION_OPERAND_WIDTH-1:0] sb_adr_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] sb_dat_i,
   input  logic [BW-1:0]                   sb_bsel_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] sb_pc_i,
   input  logic                            sb_atomic_i,
   input  logic                            halt_i,
   input  logic                            resv_valid_i,
   output logic                            dbus_req_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o,
   output logic [BW-1:0]                   dbus_bsel_o,
   input  logic                            dbus_ack_i,
   input  logic                            dbus_err_i,
   output logic                            err_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] err_adr_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] err_pc_o,
   output logic                            atomic_done_o,
   output logic                            atomic_ok_o,
   output logic                            idle_o
);

   drain_state_t                    state;
   logic [OPTION_OPERAND_WIDTH-1:0] pc;
   logic                            atomic;
   logic                            timeout;
   logic                            fail;
   logic                            done;
   logic                            pop;

`ifdef MOR1KX_SB_DRAIN_TIMEOUT_EN
   mor1kx_sb_drain_timer #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (state == FETCH),
      .en     ((state == WRITE) && !dbus_ack_i && !dbus_err_i),
      .expired(timeout)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout = 1'b0;
`endif

   // Bus completion and the next pop share a cycle so back-to-back stores cost FETCH + WRITE only.
   assign fail = dbus_err_i || timeout;
   assign done = (state == WRITE) && (dbus_ack_i || fail);
   assign pop  = !rst && !sb_empty_i && !halt_i && ((state == IDLE) || done);

   assign sb_read_o = pop;
   assign idle_o    = !rst && (state == IDLE) && sb_empty_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         dbus_req_o    <= 1'b0;
         dbus_adr_o    <= '0;
         dbus_dat_o    <= '0;
         dbus_bsel_o   <= '0;
         pc            <= '0;
         atomic        <= 1'b0;
         err_o         <= 1'b0;
         err_adr_o     <= '0;
         err_pc_o      <= '0;
         atomic_done_o <= 1'b0;
         atomic_ok_o   <= 1'b0;
      end else begin
         err_o         <= 1'b0;
         atomic_done_o <= 1'b0;
         atomic_ok_o   <= 1'b0;
         case (state)
            IDLE: begin
               if (pop)
                  state <= FETCH;
            end
            FETCH: begin
               dbus_adr_o  <= sb_adr_i;
               dbus_dat_o  <= sb_dat_i;
               dbus_bsel_o <= sb_bsel_i;
               pc          <= sb_pc_i;
               atomic      <= sb_atomic_i;
               if (sb_atomic_i && !resv_valid_i) begin
                  atomic_done_o <= 1'b1;
                  state         <= IDLE;
               end else begin
                  dbus_req_o <= 1'b1;
                  state      <= WRITE;
               end
            end
            WRITE: begin
               if (done) begin
                  dbus_req_o <= 1'b0;
                  if (fail) begin
                     err_o     <= 1'b1;
                     err_adr_o <= dbus_adr_o;
                     err_pc_o  <= pc;
                  end
                  if (atomic) begin
                     atomic_done_o <= 1'b1;
                     atomic_ok_o   <= !fail;
                  end
                  state <= pop ? FETCH : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
